// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the 8-bit CPU control sequencer:
// control-bit positions, opcodes, T-state sizing and the control word type.
package cpu_ctrl_pkg;

    localparam int unsigned CW_W = 15;

    localparam int unsigned B_HLT = 0;
    localparam int unsigned B_MI  = 1;
    localparam int unsigned B_RI  = 2;
    localparam int unsigned B_RO  = 3;
    localparam int unsigned B_IO  = 4;
    localparam int unsigned B_II  = 5;
    localparam int unsigned B_AI  = 6;
    localparam int unsigned B_AO  = 7;
    localparam int unsigned B_EO  = 8;
    localparam int unsigned B_SU  = 9;
    localparam int unsigned B_BI  = 10;
    localparam int unsigned B_OI  = 11;
    localparam int unsigned B_CE  = 12;
    localparam int unsigned B_CO  = 13;
    localparam int unsigned B_J   = 14;

    localparam int unsigned STEP_W = 3;
    localparam logic [STEP_W-1:0] MAX_STEP = 3'd4;

    typedef logic [CW_W-1:0] ctrl_word_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic {
        SEQ_RUN,
        SEQ_HALTED
    } seq_state_t;

    function automatic ctrl_word_t cbit(input int unsigned idx);
        return ctrl_word_t'(1) << idx;
    endfunction

endpackage

// File: rtl/control_rom.sv
// Combinational microcode: control word and last-step flag for a given
// opcode, T-state and ALU flags.
module control_rom
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0]        opcode,
    input  logic [STEP_W-1:0] step,
    input  logic              carry,
    input  logic              zero,
    output ctrl_word_t        word,
    output logic              last
);

    ctrl_word_t        ex2, ex3, ex4;
    logic [STEP_W-1:0] len;

    always_comb begin
        ex2 = '0;
        ex3 = '0;
        ex4 = '0;
        case (opcode)
            OP_LDA: begin
                ex2 = cbit(B_MI) | cbit(B_IO);
                ex3 = cbit(B_RO) | cbit(B_AI);
            end
            OP_ADD, OP_SUB: begin
                ex2 = cbit(B_MI) | cbit(B_IO);
                ex3 = cbit(B_RO) | cbit(B_BI);
                ex4 = cbit(B_AI) | cbit(B_EO) | ((opcode == OP_SUB) ? cbit(B_SU) : '0);
            end
            OP_STA: begin
                ex2 = cbit(B_MI) | cbit(B_IO);
                ex3 = cbit(B_AO) | cbit(B_RI);
            end
            OP_LDI: ex2 = cbit(B_IO) | cbit(B_AI);
            OP_JMP: ex2 = cbit(B_IO) | cbit(B_J);
            OP_JC:  ex2 = carry ? (cbit(B_IO) | cbit(B_J)) : '0;
            OP_JZ:  ex2 = zero  ? (cbit(B_IO) | cbit(B_J)) : '0;
            OP_OUT: ex2 = cbit(B_AO) | cbit(B_OI);
            OP_HLT: ex2 = cbit(B_HLT);
            default: ;
        endcase

        // Length ends at the last non-empty execute step, never shorter than fetch.
        if (ex4 != '0)      len = 3'd5;
        else if (ex3 != '0) len = 3'd4;
        else if (ex2 != '0) len = 3'd3;
        else                len = 3'd2;

        case (step)
            3'd0:    word = cbit(B_CO) | cbit(B_MI);
            3'd1:    word = cbit(B_RO) | cbit(B_II) | cbit(B_CE);
            3'd2:    word = ex2;
            3'd3:    word = ex3;
            3'd4:    word = ex4;
            default: word = '0;
        endcase

        // >= rather than == so any step past the end still wraps to T0.
        last = (step >= len - 3'd1) || (step >= MAX_STEP);
    end

endmodule

// File: rtl/control_sequencer.sv
// T-state counter and RUN/HALTED control for the 8-bit CPU; emits the
// per-cycle control word decoded by control_rom.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        opcode,
    input  logic              carry_flag,
    input  logic              zero_flag,
    output logic [CW_W-1:0]   control_signals,
    output logic [STEP_W-1:0] step,
    output logic              instr_last,
    output logic              halted
);

    seq_state_t        state_q;
    logic [STEP_W-1:0] step_q, step_d;
    ctrl_word_t        rom_word;
    logic              rom_last;

    control_rom u_rom (
        .opcode (opcode),
        .step   (step_q),
        .carry  (carry_flag),
        .zero   (zero_flag),
        .word   (rom_word),
        .last   (rom_last)
    );

    always_comb begin
        step_d = rom_last ? '0 : step_q + 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEQ_RUN;
            step_q  <= '0;
        end else begin
            case (state_q)
                SEQ_RUN: begin
                    step_q <= step_d;
                    if (opcode == OP_HLT && step_q == 3'd2)
                        state_q <= SEQ_HALTED;
                end
                SEQ_HALTED: step_q <= '0;
                default: begin
                    state_q <= SEQ_RUN;
                    step_q  <= '0;
                end
            endcase
        end
    end

    // Reset forcing is combinational so the bus is released the instant rst_n drops.
    always_comb begin
        if (!rst_n)                    control_signals = '0;
        else if (state_q == SEQ_HALTED) control_signals = cbit(B_HLT);
        else                           control_signals = rom_word;
    end

    assign step       = step_q;
    assign halted     = (state_q == SEQ_HALTED);
    assign instr_last = rst_n && (state_q == SEQ_RUN) && rom_last;

    logic [4:0] drivers;
    assign drivers = {control_signals[B_RO], control_signals[B_IO], control_signals[B_AO],
                      control_signals[B_EO], control_signals[B_CO]};

    a_one_driver: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(drivers));

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer against an instruction-level table model.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  opcode = 4'h0;
    logic        carry_flag = 1'b0;
    logic        zero_flag = 1'b0;
    logic [14:0] control_signals;
    logic [2:0]  step;
    logic        instr_last;
    logic        halted;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .opcode          (opcode),
        .carry_flag      (carry_flag),
        .zero_flag       (zero_flag),
        .control_signals (control_signals),
        .step            (step),
        .instr_last      (instr_last),
        .halted          (halted)
    );

    // Execute-phase words straight from the instruction table (idx 0..2 = T2..T4).
    function automatic logic [14:0] ex_word(input logic [3:0] op, input int idx, input logic c, input logic z);
        logic [14:0] t [3];
        t = '{15'h0000, 15'h0000, 15'h0000};
        case (op)
            4'h1: t = '{15'h0012, 15'h0048, 15'h0000};
            4'h2: t = '{15'h0012, 15'h0408, 15'h0140};
            4'h3: t = '{15'h0012, 15'h0408, 15'h0340};
            4'h4: t = '{15'h0012, 15'h0084, 15'h0000};
            4'h5: t = '{15'h0050, 15'h0000, 15'h0000};
            4'h6: t = '{15'h4010, 15'h0000, 15'h0000};
            4'h7: if (c) t = '{15'h4010, 15'h0000, 15'h0000};
            4'h8: if (z) t = '{15'h4010, 15'h0000, 15'h0000};
            4'hE: t = '{15'h0880, 15'h0000, 15'h0000};
            4'hF: t = '{15'h0001, 15'h0000, 15'h0000};
            default: ;
        endcase
        return t[idx];
    endfunction

    function automatic int ilen(input logic [3:0] op, input logic c, input logic z);
        for (int i = 2; i >= 0; i--)
            if (ex_word(op, i, c, z) != 15'h0) return i + 3;
        return 2;
    endfunction

    function automatic logic [14:0] exp_word(input logic [3:0] op, input int s, input logic c, input logic z);
        if (s == 0) return 15'h2002;
        if (s == 1) return 15'h1028;
        return ex_word(op, s - 2, c, z);
    endfunction

    // Called mid-cycle with the DUT sitting at T0; returns one edge past the final step.
    task automatic run_instr(input logic [3:0] op, input logic c, input logic z, input string tag);
        int len;
        logic [14:0] w;
        len = ilen(op, c, z);
        opcode = op;
        carry_flag = c;
        zero_flag = z;
        for (int s = 0; s < len; s++) begin
            #1;
            w = exp_word(op, s, c, z);
            n_cmp++;
            if (step !== 3'(s)) begin
                n_fail++;
                $display("FAIL %s op=%h step: got %0d want %0d", tag, op, step, s);
            end
            n_cmp++;
            if (control_signals !== w) begin
                n_fail++;
                $display("FAIL %s op=%h T%0d word: got %h want %h", tag, op, s, control_signals, w);
            end
            n_cmp++;
            if (instr_last !== (s == len - 1)) begin
                n_fail++;
                $display("FAIL %s op=%h T%0d instr_last: got %b want %b", tag, op, s, instr_last, s == len - 1);
            end
            n_cmp++;
            if (halted !== 1'b0) begin
                n_fail++;
                $display("FAIL %s op=%h T%0d halted: got %b want 0", tag, op, s, halted);
            end
            n_cmp++;
            if ($countones({control_signals[3], control_signals[4], control_signals[7],
                            control_signals[8], control_signals[13]}) > 1) begin
                n_fail++;
                $display("FAIL %s op=%h T%0d drivers: got %h want at most one", tag, op, s, control_signals);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (control_signals !== 15'h0000) begin
            n_fail++; $display("FAIL reset_word: got %h want 0000", control_signals);
        end
        n_cmp++;
        if (step !== 3'd0 || halted !== 1'b0 || instr_last !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: got step=%0d halted=%b last=%b want 0/0/0", step, halted, instr_last);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(4'h0, 1'b0, 1'b0, "reset_fetch");
    endtask

    task automatic test_lda();
        run_instr(4'h1, 1'b0, 1'b0, "lda");
        n_cmp++;
        if (step !== 3'd0) begin
            n_fail++; $display("FAIL lda_wrap: got step %0d want 0", step);
        end
    endtask

    task automatic test_sub_nop();
        run_instr(4'h3, 1'b1, 1'b0, "sub");
        run_instr(4'h0, 1'b0, 1'b1, "nop");
        run_instr(4'hB, 1'b1, 1'b1, "op_b");
        run_instr(4'h2, 1'b0, 1'b0, "add");
    endtask

    task automatic test_cond_jumps();
        run_instr(4'h7, 1'b0, 1'b1, "jc_nt");
        run_instr(4'h7, 1'b1, 1'b0, "jc_t");
        run_instr(4'h8, 1'b1, 1'b0, "jz_nt");
        run_instr(4'h8, 1'b0, 1'b1, "jz_t");
        opcode = 4'h8; zero_flag = 1'b1; carry_flag = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_cmp++;
        if (control_signals !== 15'h4010 || instr_last !== 1'b1) begin
            n_fail++; $display("FAIL jz_toggle_hi: got %h last=%b want 4010 last=1", control_signals, instr_last);
        end
        zero_flag = 1'b0;
        #1;
        n_cmp++;
        if (control_signals !== 15'h0000 || instr_last !== 1'b1) begin
            n_fail++; $display("FAIL jz_toggle_lo: got %h last=%b want 0000 last=1", control_signals, instr_last);
        end
        zero_flag = 1'b1;
        #1;
        n_cmp++;
        if (control_signals !== 15'h4010) begin
            n_fail++; $display("FAIL jz_toggle_back: got %h want 4010", control_signals);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (step !== 3'd0) begin
            n_fail++; $display("FAIL jz_toggle_wrap: got step %0d want 0", step);
        end
    endtask

    task automatic test_reset_mid_add();
        opcode = 4'h2; carry_flag = 1'b0; zero_flag = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++;
        if (step !== 3'd3 || control_signals !== 15'h0408) begin
            n_fail++; $display("FAIL add_t3: got step=%0d word=%h want 3/0408", step, control_signals);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (control_signals !== 15'h0000 || step !== 3'd0 || instr_last !== 1'b0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got word=%h step=%0d last=%b halted=%b want 0000/0/0/0",
                               control_signals, step, instr_last, halted);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(4'h2, 1'b1, 1'b1, "after_mid_reset");
    endtask

    task automatic test_halt();
        run_instr(4'hF, 1'b0, 1'b0, "hlt");
        for (int i = 0; i < 22; i++) begin
            opcode = 4'($urandom_range(0, 15));
            carry_flag = 1'($urandom);
            zero_flag = 1'($urandom);
            #1;
            n_cmp++;
            if (halted !== 1'b1 || control_signals !== 15'h0001 || step !== 3'd0 || instr_last !== 1'b0) begin
                n_fail++; $display("FAIL halted_hold cyc%0d: got halted=%b word=%h step=%0d last=%b want 1/0001/0/0",
                                   i, halted, control_signals, step, instr_last);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (halted !== 1'b0 || control_signals !== 15'h0000 || step !== 3'd0) begin
            n_fail++; $display("FAIL halt_reset: got halted=%b word=%h step=%0d want 0/0000/0", halted, control_signals, step);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(4'h5, 1'b0, 1'b0, "after_halt");
    endtask

    task automatic test_random_stream();
        for (int i = 0; i < 1000; i++)
            run_instr(4'($urandom_range(0, 14)), 1'($urandom), 1'($urandom), "random");
    endtask

    initial begin
        test_reset();
        test_lda();
        test_sub_nop();
        test_cond_jumps();
        test_reset_mid_add();
        test_halt();
        test_random_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
